// File: rtl/rd53_popcnt_sched_if.sv
// rd53_popcnt_sched_if
// Groups the two requester channels and the result channel of rd53_popcnt_sched.
//   master : requester/consumer side (drives req*_valid/data, rsp_ready)
//   slave  : scheduler side (drives req*_ready, rsp_valid/id/count)
// Parameter DATA_W must match the scheduler instance.
interface rd53_popcnt_sched_if #(
    parameter int DATA_W = 20
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [CNT_W-1:0]  rsp_count;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count
    );
endinterface

// File: rtl/rd53_popcnt_sched.sv
// rd53_popcnt_sched
// Shares one 5-input weight unit (rd53) between two requesters. Round-robin
// grant, then the accepted word is fed 5 bits per cycle through the weight
// unit and the partial weights are accumulated into a ones-count that is
// returned tagged with the requester id.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : rd53_popcnt_sched_if.slave (req0/req1 valid-ready-data, rsp channel)
//   busy   : high while counting or holding a response
// Optional build macro RD53_EARLY_EXIT_EN: leave COUNT as soon as the
// remaining slices are all zero (same results, shorter latency).
//
// state | meaning
// IDLE  | waiting for a request; ready given to the granted requester
// COUNT | one 5-bit slice weighed and accumulated per cycle
// RESP  | result held on rsp_* until the consumer takes it
module rd53_popcnt_sched #(
    parameter int DATA_W = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    rd53_popcnt_sched_if.slave  bus,
    output logic                busy
);
    localparam int SLICES = DATA_W / 5;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    generate
        if ((DATA_W % 5) != 0 || DATA_W < 5) begin : g_bad_width
            $error("rd53_popcnt_sched: DATA_W must be a multiple of 5 and >= 5");
        end
    endgenerate

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]        state;
    logic              rr_ptr;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [CNT_W-1:0]  rsp_count_q;
    logic [CNT_W-1:0]  acc;
    logic [IDX_W-1:0]  slice_idx;
    logic [DATA_W-1:0] shift_q;

    logic              gnt0;
    logic              gnt1;
    logic [2:0]        w5;
    logic [CNT_W-1:0]  acc_nxt;
    logic [DATA_W-1:0] shift_nxt;
    logic              last_slice;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (rr_ptr == 1'b0) begin
                if (bus.req0_valid)      gnt0 = 1'b1;
                else if (bus.req1_valid) gnt1 = 1'b1;
            end else begin
                if (bus.req1_valid)      gnt1 = 1'b1;
                else if (bus.req0_valid) gnt0 = 1'b1;
            end
        end
    end

    // rd53 weight unit: ones in the low slice
    assign w5 = {2'b00, shift_q[0]} + {2'b00, shift_q[1]} + {2'b00, shift_q[2]}
              + {2'b00, shift_q[3]} + {2'b00, shift_q[4]};
    assign acc_nxt   = acc + CNT_W'(w5);
    assign shift_nxt = shift_q >> 5;

`ifdef RD53_EARLY_EXIT_EN
    assign last_slice = (slice_idx == IDX_W'(SLICES - 1)) || (shift_nxt == '0);
`else
    assign last_slice = (slice_idx == IDX_W'(SLICES - 1));
`endif

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign bus.req0_ready = gnt0 & rst_n;
    assign bus.req1_ready = gnt1 & rst_n;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_count  = rsp_count_q;
    assign busy           = (state == COUNT) || (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_count_q <= '0;
            acc         <= '0;
            slice_idx   <= '0;
            shift_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        shift_q   <= gnt1 ? bus.req1_data : bus.req0_data;
                        acc       <= '0;
                        slice_idx <= '0;
                        rsp_id_q  <= gnt1;
                        rr_ptr    <= ~gnt1;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    acc       <= acc_nxt;
                    shift_q   <= shift_nxt;
                    slice_idx <= slice_idx + IDX_W'(1);
                    if (last_slice) begin
                        rsp_count_q <= acc_nxt;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rd53_popcnt_sched.sv
module tb_rd53_popcnt_sched;
    localparam int DATA_W = 20;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    logic clk;
    logic rst_n;
    logic busy;
    int   cyc;
    int   total;
    int   bad;
    logic [CNT_W:0] sb[$];

    rd53_popcnt_sched_if #(.DATA_W(DATA_W)) bus ();

    rd53_popcnt_sched #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected cycles from accept to first rsp_valid cycle.
    function automatic int exp_lat(input logic [DATA_W-1:0] d);
`ifdef RD53_EARLY_EXIT_EN
        int k;
        k = 1;
        for (int s = 0; s < DATA_W / 5; s++)
            if (d[s*5 +: 5] != 5'd0) k = s + 1;
        return k + 1;
`else
        return d == d ? DATA_W / 5 + 1 : 0;
`endif
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req0_valid && bus.req0_ready)
                sb.push_back({1'b0, CNT_W'($countones(bus.req0_data))});
            if (bus.req1_valid && bus.req1_ready)
                sb.push_back({1'b1, CNT_W'($countones(bus.req1_data))});
            check("ready_outside_idle", int'((bus.req0_ready | bus.req1_ready) & busy), 0);
            check("single_ready", int'(bus.req0_ready & bus.req1_ready), 0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    logic [CNT_W:0] e;
                    e = sb.pop_front();
                    check("rsp_id", int'(bus.rsp_id), int'(e[CNT_W]));
                    check("rsp_count", int'(bus.rsp_count), int'(e[CNT_W-1:0]));
                end
            end
        end
    end

    task automatic run_one(input bit id, input logic [DATA_W-1:0] d);
        int  t;
        bit  got;
        @(posedge clk); #1;
        if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; end
        else    begin bus.req0_valid = 1'b1; bus.req0_data = d; end
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = id ? bus.req1_ready : bus.req0_ready;
        end
        check("grant", int'(got), 1);
        t = cyc;
        check("busy_at_accept", int'(busy), 0);
        @(posedge clk); #1;
        if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = bus.rsp_valid;
            if (!got) check("busy_in_count", int'(busy), 1);
        end
        check("rsp_seen", int'(got), 1);
        check("latency", cyc - t, exp_lat(d));
        check("busy_in_resp", int'(busy), 1);
    endtask

    // Both requesters valid together; requester 0 must win and requester 1
    // must be accepted exactly one cycle after the first response handshake.
    task automatic dual(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        int a0, a1, hs;
        bit got;
        a0 = -1; a1 = -1; hs = -1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_data = d0;
        bus.req1_valid = 1'b1; bus.req1_data = d1;
        for (int n = 0; n < 60 && a1 < 0; n++) begin
            @(negedge clk);
            if (bus.req0_ready && a0 < 0) a0 = cyc;
            if (bus.req1_ready) a1 = cyc;
            if (bus.rsp_valid && bus.rsp_ready && hs < 0) hs = cyc;
            @(posedge clk); #1;
            if (a0 >= 0) bus.req0_valid = 1'b0;
            if (a1 >= 0) bus.req1_valid = 1'b0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("winner_is_0", int'(a0 >= 0 && a0 < a1), 1);
        check("second_accept_gap", a1 - hs, 1);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bus.rsp_valid;
        end
        check("second_rsp_seen", int'(got), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 20'hFFFFF;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.rsp_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_req0_ready", int'(bus.req0_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_rsp_id", int'(bus.rsp_id), 0);
        check("rst_rsp_count", int'(bus.rsp_count), 0);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;

        run_one(1'b0, 20'hFFFFF);
        run_one(1'b1, 20'hA5A5A);
        run_one(1'b1, 20'h00000);
        run_one(1'b0, 20'h0001F);
        run_one(1'b0, 20'h80000);
        for (int i = 0; i < 3; i++) run_one(1'(i), 20'($urandom));

        // fresh reset so round-robin restarts at requester 0
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        dual(20'h0001F, 20'h003E0);

        // backpressure: response must hold while rsp_ready is low
        bus.rsp_ready = 1'b0;
        run_one(1'b0, 20'h12345);
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_data = 20'h00FFF;
        bus.req1_valid = 1'b1; bus.req1_data = 20'h00007;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", int'(bus.rsp_valid), 1);
            check("hold_id", int'(bus.rsp_id), 0);
            check("hold_count", int'(bus.rsp_count), 7);
            check("hold_ready0", int'(bus.req0_ready), 0);
            check("hold_ready1", int'(bus.req1_ready), 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("hs_valid", int'(bus.rsp_valid), 1);
        @(negedge clk);
        check("after_hs_busy", int'(busy), 0);
        check("after_hs_valid", int'(bus.rsp_valid), 0);

        // reset during the second COUNT slice of a requester-0 word
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_data = 20'hFFFFF;
        begin
            bit got;
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = bus.req0_ready;
            end
            check("midrst_grant", int'(got), 1);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_rsp_valid", int'(bus.rsp_valid), 0);
        check("midrst_rsp_count", int'(bus.rsp_count), 0);
        check("midrst_rsp_id", int'(bus.rsp_id), 0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", int'(bus.rsp_valid), 0);
        end
        dual(20'hFFFFF, 20'h00001);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rd53_popcnt_sched.md
Name: rd53_popcnt_sched

Overview:
Sequencer and arbiter that shares one 5-input weight unit (rd53 function: 3-bit count of ones in 5 bits) between two requesters. Each request carries a DATA_W-bit word. The block arbitrates round-robin, feeds the word through the weight unit 5 bits per cycle, accumulates the partial weights, and returns the total ones-count tagged with the requester id. It sits between the rd53 combinational datapath and the blocks that need wide popcounts.

Parameters:
DATA_W, 20, request word width; must be a multiple of 5 and >= 5, otherwise elaboration error
SLICES, DATA_W/5, derived localparam: number of 5-bit slices per word
CNT_W, $clog2(DATA_W+1), derived localparam: result width (5 for the default)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req0_valid  in  1  requester 0 has a word
req0_ready  out  1  requester 0 word accepted this cycle
req0_data  in  DATA_W  requester 0 word
req1_valid  in  1  requester 1 has a word
req1_ready  out  1  requester 1 word accepted this cycle
req1_data  in  DATA_W  requester 1 word
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that owns the result
rsp_count  out  CNT_W  ones-count of the accepted word
busy  out  1  high in COUNT or RESP

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_count=0, acc=0, slice_idx=0, shift register=0, busy=0. req*_ready=0 while rst_n is low.
- State IDLE:
  - reqN_ready is combinational and high only for the granted requester.
  - Grant goes to rr_ptr if that requester is valid, else to the other one if it is valid.
  - On grant: capture data into the shift register, set acc=0, slice_idx=0, latch the owner id, set rr_ptr to the non-granted requester, go to COUNT.
  - With no valid request, stay in IDLE.
- State COUNT, one slice per cycle:
  - acc <= acc + w5(shift[4:0]), where w5 is the rd53 weight (0..5) zero-extended to CNT_W.
  - shift is shifted right by 5 with zero fill; slice_idx increments.
  - When slice_idx == SLICES-1, go to RESP with rsp_count = the final sum and rsp_valid=1.
  - acc cannot overflow: the maximum is DATA_W, which fits in CNT_W.
- State RESP:
  - rsp_valid, rsp_id and rsp_count stay stable until rsp_ready is high.
  - On the handshake: rsp_valid <= 0, go to IDLE.
  - No new request is accepted in the handshake cycle; the earliest next accept is the cycle after.
- Latency: accept at cycle T; rsp_valid is high from T+SLICES+1 (T+5 for the default).
- Throughput: one word per SLICES+2 cycles when rsp_ready is held high.
- Ready rules:
  - req*_ready is never high outside IDLE.
  - A requester that drops valid before it is granted is simply skipped.
  - The grant decision looks at current-cycle valids only.
- Simultaneous valids: rr_ptr decides the winner and the loser is served next.
  - From reset, 0 wins, then 1.
- Reset mid-operation (COUNT or RESP): the in-flight word is discarded and no response is produced.
- rsp_valid deasserts immediately on reset assertion, since reset is asynchronous.

Optional Feature:
Macro RD53_EARLY_EXIT_EN.
- Defined: in COUNT, if the shift register after the shift is all zeros, the block goes to RESP this cycle regardless of slice_idx, with rsp_count = the updated sum. Latency is T+k+1, where k = 1 + index of the highest non-zero slice (k=1 for a zero word).
- Undefined: always exactly SLICES COUNT cycles; latency is fixed at T+SLICES+1.
- Results are identical in both builds.

Test Plan:
- req0_data=20'hFFFFF accepted at T, rsp_ready=1 -> rsp_valid at T+5, rsp_count=20, rsp_id=0, busy high T+1..T+5.
- req1_data=20'hA5A5A, alone -> rsp_count=10, rsp_id=1. Then req1_data=20'h00000 -> rsp_count=0; latency T+5 without the macro, T+2 with RD53_EARLY_EXIT_EN.
- Both valid from reset with distinct words 20'h0001F and 20'h003E0, both held -> first response id=0 count=5, second response id=1 count=5; the second accept is exactly 1 cycle after the first rsp handshake.
- Response held with rsp_ready=0 for 10 cycles -> rsp_valid, rsp_id and rsp_count constant; req*_ready stays 0 even with valid requests; the handshake returns the block to IDLE.
- rst_n pulsed low during COUNT (2nd slice) -> outputs go to reset values asynchronously, no response emitted; the next request is counted correctly and granted to requester 0 first.
- RD53_EARLY_EXIT_EN with 20'h0001F -> rsp_valid at T+2, count=5; with 20'h80000 -> T+5, count=1.
